sram_port_ctrl: RTL
===================

// Module: sram_port_ctrl
// PURPOSE
//  Initiator-side controller for the 128x9 single-port block SRAM wrapper (bypass read mode).
//  Accepts valid/ready read/write requests from the processor core and drives ce/wre/ad/din.
//  Captures dout one cycle after a read and returns it through a valid/ready response buffer.
//  Read responses return strictly in request order.
// PARAMETERS
//  ADDR_W     7  SRAM address width (depth = 2**ADDR_W)
//  DATA_W     9  SRAM data width
//  RSP_DEPTH  2  response buffer entries (power of two, >=2); also caps outstanding reads
// PORTS
//  clk        in   1       clock; all SRAM ports sampled on rising edge
//  reset      in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when req_valid & req_ready at rising edge
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       read data available
//  rsp_ready  in   1       consumer takes rsp_rdata when rsp_valid & rsp_ready
//  rsp_rdata  out  DATA_W  read data, head of response buffer
//  busy       out  1       controller not accepting requests (clear sequence running)
//  sram_ce    out  1       SRAM clock enable
//  sram_oce   out  1       SRAM output clock enable; constant 1
//  sram_reset out  1       SRAM sync reset; constant 0
//  sram_wre   out  1       SRAM write enable
//  sram_ad    out  ADDR_W  SRAM address
//  sram_din   out  DATA_W  SRAM write data
//  sram_dout  in   DATA_W  SRAM read data
// BEHAVIOUR
//  - Reset (reset=0): rsp_valid=0, buffer count=0, inflight=0; busy=0 and req_ready=1 (no clear).
//  - Issue is combinational pass-through: sram_ce=req_valid&req_ready, sram_wre=req_we,
//    sram_ad=req_addr, sram_din=req_wdata; sram_ce=0 otherwise.
//  - Write: completes at the acceptance edge E0. No response is produced.
//  - Read accepted at E0: inflight=1 after E0; sram_dout is captured into the buffer at E1.
//    rsp_valid is high in the cycle after E1, so latency is 2 edges.
//  - Credit: outstanding = inflight + count.
//    req_ready=0 for reads if outstanding >= RSP_DEPTH and no pop occurs this cycle.
//    Writes are always ready unless busy. req_ready depends only on req_we, not on req_valid.
//  - Simultaneous capture and pop: count unchanged. FIFO pointers wrap modulo RSP_DEPTH.
//  - Overflow is impossible by credit. Underflow is impossible because rsp_valid = (count != 0).
//  - Write to the address of an in-flight read is legal. The read returns old data because it
//    was captured at its issue edge.
//  - Reset mid-operation: pending responses and the in-flight read are discarded immediately.
//    The SRAM array contents are unaffected, except the clear sequence restarts when enabled.
// CONFIGURATION
//  SRAM_CLEAR_EN defined:
//   - After reset release, FSM CLEAR writes 0 to addresses 0..2**ADDR_W-1, one per cycle
//     (sram_ce=1, sram_wre=1, sram_din=0). busy=1 and req_ready=0 throughout.
//   - After the last address the FSM enters RUN (busy=0). Total: 2**ADDR_W cycles.
//  SRAM_CLEAR_EN undefined: FSM starts in RUN, busy is tied to 0, no clear counter.
// TESTING
//  1. Write 0x1A5 to addr 5, then read addr 5 -> rsp_rdata=0x1A5, rsp_valid 2 edges after the read.
//  2. Reads addr 0..3 back-to-back with rsp_ready=1 -> 4 in-order responses, one per cycle,
//     req_ready stays 1.
//  3. rsp_ready=0, 3 reads requested -> req_ready=0 after 2 accepted.
//     rsp_ready=1 -> both responses in order, 3rd read accepted, no data lost.
//  4. count=2 with pop and new read accept in the same cycle -> accepted, ordering preserved.
//  5. reset low while rsp_valid=1 -> rsp_valid=0 asynchronously. After release, no stale response.
//  6. SRAM_CLEAR_EN: busy=1 for 128 cycles after reset.
//     Then read addr 127 (pre-written 0x0FF) -> rsp_rdata=0x000.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for a 128x9 single-port block SRAM in bypass read mode, with an in-order read response buffer.
// Optional power-up clear of the whole array is built in when SRAM_CLEAR_EN is defined.
module sram_port_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 9,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sram_ce,
    output logic              sram_oce,
    output logic              sram_reset,
    output logic              sram_wre,
    output logic [ADDR_W-1:0] sram_ad,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];

    logic              clr_active;
    logic [ADDR_W-1:0] clr_addr;
    logic              pop;
    logic              rd_accept;
    logic              credit_ok;
    logic [CNT_W:0]    outstanding;

`ifdef SRAM_CLEAR_EN
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q, busy_d;

    // One zero-write per cycle; the last address hands over to RUN.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == S_CLEAR) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == {ADDR_W{1'b1}}) begin
                state_d = S_RUN;
            end
        end
        busy_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign clr_active = busy_q;
    assign clr_addr   = clr_addr_q;
`else
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
`endif

    // Both channels are valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; ready never looks at valid, and valid never looks at ready.
    assign rsp_valid   = (count_q != '0);
    assign rsp_rdata   = rsp_mem[rptr_q];
    assign pop         = rsp_valid & rsp_ready;

    // Every accepted read owns a buffer slot from issue until it is popped.
    assign outstanding = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    assign credit_ok   = (outstanding < DEPTH_C) || pop;
    assign req_ready   = !clr_active && (req_we || credit_ok);
    assign rd_accept   = req_valid && req_ready && !req_we;
    assign busy        = clr_active;

    assign sram_ce    = clr_active | (req_valid & req_ready);
    assign sram_wre   = clr_active | req_we;
    assign sram_ad    = clr_active ? clr_addr : req_addr;
    assign sram_din   = clr_active ? '0 : req_wdata;
    assign sram_oce   = 1'b1;
    assign sram_reset = 1'b0;

    always_comb begin
        inflight_d = rd_accept;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (inflight_q && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!inflight_q && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (inflight_q) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // The SRAM registered dout at the issue edge, so this picks up the data the read saw.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            rsp_mem[wptr_q] <= sram_dout;
        end
    end

endmodule
